// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle restoring divider for DIV/DIVU/REM/REMU with pipeline stall.
// Optional DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip straight to FINISH.
module div_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  rd_in,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  rd_out,
  output logic        regwrite
);
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  state_t state;
  logic [4:0] count, rd_l;
  logic [1:0] f3;
  logic [31:0] a_l, b_l, q, r, d, q_n, r_n;
  logic [32:0] diff;
  logic accept;
  function automatic logic [31:0] fixup(input logic [1:0] op, input logic [31:0] x, y, qt, rm);
    logic sgn, dz, ovf;
    logic [31:0] qs, rs;
    sgn = !op[0];
    dz = y == 32'd0;
    ovf = sgn && x == 32'h8000_0000 && y == 32'hffff_ffff;
    qs = sgn && (x[31] ^ y[31]) ? -qt : qt;
    rs = sgn && x[31] ? -rm : rm;
    return dz ? (op[1] ? x : 32'hffff_ffff) : ovf ? (op[1] ? 32'd0 : 32'h8000_0000) : op[1] ? rs : qs;
  endfunction
  assign accept = state == IDLE && start && funct3[2];
  assign diff = {r, q[31]} - {1'b0, d};
  assign q_n = {q[30:0], !diff[32]};
  assign r_n = diff[32] ? {r[30:0], q[31]} : diff[31:0];
  assign stall = accept || state == RUN;
  assign busy = state != IDLE;
  assign regwrite = done && rd_out != 5'd0;
`ifdef DIV_EARLY_OUT_EN
  logic special;
  assign special = b == 32'd0 || (!funct3[0] && a == 32'h8000_0000 && b == 32'hffff_ffff);
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= 5'd0;
      done <= 1'b0;
      result <= 32'd0;
      rd_out <= 5'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          f3 <= funct3[1:0];
          a_l <= a;
          b_l <= b;
          rd_l <= rd_in;
          count <= 5'd0;
          q <= !funct3[0] && a[31] ? -a : a;
          d <= !funct3[0] && b[31] ? -b : b;
          r <= 32'd0;
`ifdef DIV_EARLY_OUT_EN
          if (special) begin
            state <= FINISH;
            done <= 1'b1;
            result <= fixup(funct3[1:0], a, b, 32'd0, 32'd0);
            rd_out <= rd_in;
          end else
            state <= RUN;
`else
          state <= RUN;
`endif
        end
        RUN: begin
          q <= q_n;
          r <= r_n;
          count <= count + 5'd1;
          if (count == 5'd31) begin
            state <= FINISH;
            done <= 1'b1;
            result <= fixup(f3, a_l, b_l, q_n, r_n);
            rd_out <= rd_l;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed vectors with a scoreboard queue checked by a done-driven monitor.
module tb_div_sequencer;
  logic clk = 0, rst, start;
  logic [2:0] funct3;
  logic [31:0] a, b, result;
  logic [4:0] rd_in, rd_out;
  logic stall, busy, done, regwrite;
  int cyc = 0, checks = 0, errors = 0;
`ifdef DIV_EARLY_OUT_EN
  localparam int EL = 1;
`else
  localparam int EL = 33;
`endif
  typedef struct {logic [31:0] res; logic [4:0] rd; logic rw; int acc; int lat;} exp_t;
  exp_t sbq[$];

  div_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .a(a), .b(b), .rd_in(rd_in),
    .stall(stall), .busy(busy), .done(done), .result(result), .rd_out(rd_out), .regwrite(regwrite)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) if (done) begin
    exp_t e;
    chk("done_expected", 32'(sbq.size() != 0), 32'd1);
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk("result", result, e.res);
      chk("rd_out", {27'd0, rd_out}, {27'd0, e.rd});
      chk("regwrite", {31'd0, regwrite}, {31'd0, e.rw});
      chk("latency", cyc - e.acc, e.lat);
    end
  end

  // Called at negedge+1; holds start while stalled and returns in the FINISH cycle.
  task automatic go(input logic [2:0] f, input logic [31:0] x, y, input logic [4:0] rd,
                    input logic [31:0] res, input int lat, input int exp_w, input string nm);
    int w = 0, n = 0;
    exp_t e;
    start = 1; funct3 = f; a = x; b = y; rd_in = rd;
    #1;
    while (!stall && w < 5) begin @(negedge clk); #1; w++; end
    chk({nm, "_accept_wait"}, w, exp_w);
    e.res = res; e.rd = rd; e.rw = rd != 5'd0; e.acc = cyc; e.lat = lat;
    sbq.push_back(e);
    do begin n++; @(negedge clk); #1; end while (stall && n < 100);
    chk({nm, "_stall_cycles"}, n, lat);
    start = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int t = 0;
    rst = 1; start = 0; funct3 = 0; a = 0; b = 0; rd_in = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_rd_out", {27'd0, rd_out}, 32'd0);
    chk("rst_regwrite", {31'd0, regwrite}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    rst = 0;
    @(negedge clk); #1;
    start = 1; funct3 = 3'b000; a = 100; b = 7; rd_in = 5;
    #1 chk("nondiv_stall", {31'd0, stall}, 32'd0);
    @(negedge clk); #1;
    chk("nondiv_busy", {31'd0, busy}, 32'd0);
    start = 0;
    go(3'b101, 32'd100, 32'd7, 5'd5, 32'd14, 33, 0, "divu_100_7");
    go(3'b110, 32'hffff_fff9, 32'd2, 5'd3, 32'hffff_ffff, 33, 1, "rem_m7_2");
    go(3'b100, 32'hffff_fff9, 32'd2, 5'd4, 32'hffff_fffd, 33, 1, "div_m7_2");
    go(3'b100, 32'd5, 32'd0, 5'd6, 32'hffff_ffff, EL, 1, "div_5_0");
    go(3'b111, 32'd5, 32'd0, 5'd7, 32'd5, EL, 1, "remu_5_0");
    go(3'b100, 32'h8000_0000, 32'hffff_ffff, 5'd8, 32'h8000_0000, EL, 1, "div_ovf");
    @(negedge clk); #1;
    start = 1; funct3 = 3'b101; a = 9; b = 3; rd_in = 1;
    repeat (11) @(negedge clk);
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    rst = 1; start = 0;
    @(negedge clk); #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_regwrite", {31'd0, regwrite}, 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_stall", {31'd0, stall}, 32'd0);
    rst = 0;
    go(3'b101, 32'd9, 32'd3, 5'd1, 32'd3, 33, 0, "divu_9_3_after_rst");
    go(3'b101, 32'd9, 32'd3, 5'd0, 32'd3, 33, 1, "divu_9_3_rd0");
    go(3'b111, 32'd9, 32'd4, 5'd2, 32'd1, 33, 1, "remu_9_4_b2b");
    go(3'b110, 32'h8000_0000, 32'hffff_ffff, 5'd9, 32'd0, EL, 1, "rem_ovf");
    while (sbq.size() != 0 && t < 100) begin @(negedge clk); t++; end
    chk("scoreboard_drained", sbq.size(), 32'd0);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
